// File: rtl/ifft_r2sdf_stage_if.sv
// Sample stream into and out of one R2SDF butterfly stage, plus the twiddle
// ROM address that travels alongside each output sample.
interface ifft_r2sdf_stage_if;
  // Valid-only handshake: a sample transfers on every rising edge where
  // in_valid is 1 (no ready, no back-pressure); out_valid marks the single
  // cycle in which out_re/out_im/tw_addr/tw_en carry a new result.
  logic               in_valid;
  logic signed [12:0] in_re;
  logic signed [12:0] in_im;
  logic               out_valid;
  logic signed [12:0] out_re;
  logic signed [12:0] out_im;
  logic [3:0]         tw_addr;
  logic               tw_en;

  modport master (
    output in_valid, in_re, in_im,
    input  out_valid, out_re, out_im, tw_addr, tw_en
  );

  modport slave (
    input  in_valid, in_re, in_im,
    output out_valid, out_re, out_im, tw_addr, tw_en
  );
endinterface

// File: rtl/ifft_r2sdf_stage.sv
// Radix-2 single-path delay-feedback butterfly stage: DIF sum/difference pairs
// over a DEPTH-long feedback line, with the matching twiddle ROM address.
module ifft_r2sdf_stage #(
  parameter int DEPTH = 16,
  parameter int SCALE = 0
) (
  input logic              clk,
  input logic              rst_n,
  ifft_r2sdf_stage_if.slave bus
);
  localparam int         TW_SHIFT  = $clog2(16 / DEPTH);
  localparam logic [4:0] CNT_LAST  = 5'(2 * DEPTH - 1);
  localparam logic [4:0] DEPTH_C   = 5'(DEPTH);
  localparam logic [3:0] SLOT_MASK = 4'(DEPTH - 1);

  logic [4:0]         cnt;
  logic               primed;
  logic               phase;
  logic [3:0]         slot;
  logic [3:0]         tw_next;
  logic signed [12:0] line_re [DEPTH];
  logic signed [12:0] line_im [DEPTH];
  logic signed [12:0] d_re, d_im;
  logic signed [12:0] sum_re, sum_im;
  logic signed [12:0] diff_re, diff_im;
  logic signed [12:0] wr_re, wr_im;

  // Bring a 14-bit butterfly result back to S3.9: halve (floor) or clamp.
  function automatic logic signed [12:0] fit(input logic signed [13:0] v);
    if (SCALE != 0)
      return v[13:1];
    else if (v[13] != v[12])
      return v[13] ? 13'sh1000 : 13'sh0fff;
    else
      return v[12:0];
  endfunction

  assign phase   = cnt >= DEPTH_C;
  assign slot    = cnt[3:0] & SLOT_MASK;
  assign tw_next = slot << TW_SHIFT;

  assign d_re    = line_re[DEPTH-1];
  assign d_im    = line_im[DEPTH-1];
  assign sum_re  = fit({d_re[12], d_re} + {bus.in_re[12], bus.in_re});
  assign sum_im  = fit({d_im[12], d_im} + {bus.in_im[12], bus.in_im});
  assign diff_re = fit({d_re[12], d_re} - {bus.in_re[12], bus.in_re});
  assign diff_im = fit({d_im[12], d_im} - {bus.in_im[12], bus.in_im});
  assign wr_re   = phase ? diff_re : bus.in_re;
  assign wr_im   = phase ? diff_im : bus.in_im;

  // Shift-register delay line; contents before the first butterfly are
  // masked by primed, so no reset is needed here.
  always_ff @(posedge clk) begin
    if (bus.in_valid) begin
      line_re[0] <= wr_re;
      line_im[0] <= wr_im;
      for (int k = 1; k < DEPTH; k++) begin
        line_re[k] <= line_re[k-1];
        line_im[k] <= line_im[k-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt           <= '0;
      primed        <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_re    <= '0;
      bus.out_im    <= '0;
      bus.tw_addr   <= '0;
      bus.tw_en     <= 1'b0;
    end else begin
      bus.out_valid <= bus.in_valid && (phase || primed);
      if (bus.in_valid) begin
        cnt <= (cnt == CNT_LAST) ? 5'd0 : cnt + 5'd1;
        if (phase) begin
          primed      <= 1'b1;
          bus.out_re  <= sum_re;
          bus.out_im  <= sum_im;
          bus.tw_addr <= 4'd0;
          bus.tw_en   <= 1'b0;
        end else begin
          bus.out_re  <= d_re;
          bus.out_im  <= d_im;
          bus.tw_addr <= tw_next;
          bus.tw_en   <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_ifft_r2sdf_stage.sv
// Bench for ifft_r2sdf_stage: several DEPTH/SCALE instances on a shared data bus,
// a pair-level reference model, directed literal checks and random streams.
module tb_ifft_r2sdf_stage;
  localparam int NI = 7;
  localparam logic [NI-1:0][4:0] DEPS   = {5'd2, 5'd16, 5'd4, 5'd8, 5'd1, 5'd1, 5'd16};
  localparam logic [NI-1:0]      SCALES = 7'b0100100;
  localparam int W = 33;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic               in_valid = 1'b0;
  logic [NI-1:0]      sel = '0;
  logic signed [12:0] in_re = '0;
  logic signed [12:0] in_im = '0;

  logic [NI-1:0]      o_valid;
  logic [NI-1:0]      o_en;
  logic signed [12:0] o_re [NI];
  logic signed [12:0] o_im [NI];
  logic [3:0]         o_addr [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    ifft_r2sdf_stage_if ifc ();
    assign ifc.in_valid = in_valid & sel[g];
    assign ifc.in_re    = in_re;
    assign ifc.in_im    = in_im;
    ifft_r2sdf_stage #(
      .DEPTH(int'(DEPS[g])),
      .SCALE(int'(SCALES[g]))
    ) u_dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (ifc.slave)
    );
    assign o_valid[g] = ifc.out_valid;
    assign o_re[g]    = ifc.out_re;
    assign o_im[g]    = ifc.out_im;
    assign o_addr[g]  = ifc.tw_addr;
    assign o_en[g]    = ifc.tw_en;
  end

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] held [NI];
  int hist_re [NI][$];
  int hist_im [NI][$];

  function automatic void check(string name, int act, int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endfunction

  // {valid, data_care, re, im, tw_en, tw_addr}
  function automatic logic [W-1:0] pack(bit v, bit care, int re, int im, bit en, int addr);
    return {v, care, 13'(re), 13'(im), en, 4'(addr)};
  endfunction

  function automatic int fix_m(int v, bit sc);
    if (sc) return (v < 0) ? -((1 - v) / 2) : v / 2;
    if (v > 4095) return 4095;
    if (v < -4096) return -4096;
    return v;
  endfunction

  // Sample n pairs with sample n-DEPTH inside each 2*DEPTH block; the second
  // half yields sums, the next block's first half yields the differences.
  function automatic logic [W-1:0] step(int i, int re, int im);
    int d, n, pos, addr;
    bit sc;
    d   = int'(DEPS[i]);
    sc  = SCALES[i];
    n   = hist_re[i].size();
    pos = n % (2 * d);
    hist_re[i].push_back(re);
    hist_im[i].push_back(im);
    if (pos >= d)
      return pack(1'b1, 1'b1, fix_m(hist_re[i][n-d] + re, sc),
                  fix_m(hist_im[i][n-d] + im, sc), 1'b0, 0);
    addr = pos * (16 / d);
    if (n >= 2 * d)
      return pack(1'b1, 1'b1, fix_m(hist_re[i][n-2*d] - hist_re[i][n-d], sc),
                  fix_m(hist_im[i][n-2*d] - hist_im[i][n-d], sc), 1'b1, addr);
    return pack(1'b0, 1'b0, 0, 0, 1'b1, addr);
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (!rst_n) begin
        hist_re[i].delete();
        hist_im[i].delete();
        held[i] = pack(1'b0, 1'b1, 0, 0, 1'b0, 0);
      end else if (in_valid && sel[i]) begin
        held[i] = step(i, int'(in_re), int'(in_im));
      end else begin
        held[i][W-1] = 1'b0;
      end
      exp_q.push_back(held[i]);
    end
    #1;
    for (int i = 0; i < NI; i++) begin
      logic [W-1:0]       e;
      logic signed [12:0] er, ei;
      e  = exp_q.pop_front();
      er = e[30:18];
      ei = e[17:5];
      check($sformatf("model inst%0d out_valid", i), int'(o_valid[i]), int'(e[32]));
      if (e[31]) begin
        check($sformatf("model inst%0d out_re", i), int'(o_re[i]), int'(er));
        check($sformatf("model inst%0d out_im", i), int'(o_im[i]), int'(ei));
      end
      check($sformatf("model inst%0d tw_en", i), int'(o_en[i]), int'(e[4]));
      check($sformatf("model inst%0d tw_addr", i), int'(o_addr[i]), int'(e[3:0]));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(logic [NI-1:0] s, int re, int im);
    @(negedge clk);
    in_valid = 1'b1;
    sel      = s;
    in_re    = 13'(re);
    in_im    = 13'(im);
    @(posedge clk);
    #2;
  endtask

  task automatic idle(int n);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #2;
  endtask

  function automatic int rnd13();
    if ($urandom_range(0, 9) == 0) return ($urandom_range(0, 1) != 0) ? 4095 : -4096;
    return int'($urandom_range(0, 8191)) - 4096;
  endfunction

  task automatic check_all_zero(string tag);
    for (int i = 0; i < NI; i++) begin
      check($sformatf("%s inst%0d out_valid", tag, i), int'(o_valid[i]), 0);
      check($sformatf("%s inst%0d out_re", tag, i), int'(o_re[i]), 0);
      check($sformatf("%s inst%0d out_im", tag, i), int'(o_im[i]), 0);
      check($sformatf("%s inst%0d tw_en", tag, i), int'(o_en[i]), 0);
      check($sformatf("%s inst%0d tw_addr", tag, i), int'(o_addr[i]), 0);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) @(posedge clk);
    #2;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // DC frame on DEPTH=16, SCALE=0
    for (int k = 1; k <= 48; k++) begin
      drive(7'b0000001, (k <= 32) ? 512 : 0, 0);
      if (k <= 16) begin
        check("dc fill out_valid", int'(o_valid[0]), 0);
      end else if (k <= 32) begin
        check("dc sum out_valid", int'(o_valid[0]), 1);
        check("dc sum out_re", int'(o_re[0]), 1024);
        check("dc sum tw_en", int'(o_en[0]), 0);
        check("dc sum tw_addr", int'(o_addr[0]), 0);
      end else begin
        check("dc diff out_valid", int'(o_valid[0]), 1);
        check("dc diff out_re", int'(o_re[0]), 0);
        check("dc diff tw_en", int'(o_en[0]), 1);
        check("dc diff tw_addr", int'(o_addr[0]), k - 33);
      end
    end
    idle(1);

    // saturation on DEPTH=1, SCALE=0
    drive(7'b0000010, 3072, 0);
    drive(7'b0000010, 3072, 0);
    check("sat sum clamp", int'(o_re[1]), 4095);
    drive(7'b0000010, 3072, 0);
    check("sat zero diff", int'(o_re[1]), 0);
    drive(7'b0000010, -3072, 0);
    check("sat sum cancel", int'(o_re[1]), 0);
    drive(7'b0000010, -3072, 0);
    check("sat diff pos clamp", int'(o_re[1]), 4095);
    drive(7'b0000010, 3072, 0);
    drive(7'b0000010, 0, 0);
    check("sat diff neg clamp", int'(o_re[1]), -4096);
    idle(1);

    // scaling on DEPTH=1, SCALE=1
    drive(7'b0000100, 3072, 0);
    drive(7'b0000100, 3072, 0);
    check("scale sum", int'(o_re[2]), 3072);
    drive(7'b0000100, -3, 0);
    drive(7'b0000100, 0, 0);
    check("scale floor sum", int'(o_re[2]), -2);
    drive(7'b0000100, 0, 0);
    check("scale floor diff", int'(o_re[2]), -2);
    idle(1);

    // twiddle addressing on DEPTH=4
    for (int k = 0; k < 8; k++) begin
      drive(7'b0010000, rnd13(), rnd13());
      if (k < 4) begin
        check("addr d4 tw_en", int'(o_en[4]), 1);
        check("addr d4 tw_addr", int'(o_addr[4]), 4 * k);
      end
    end
    idle(1);

    // stalls on DEPTH=8 at cnt=5 and cnt=8 of the second block
    for (int k = 0; k < 21; k++) drive(7'b0001000, rnd13(), rnd13());
    for (int j = 0; j < 3; j++) begin
      idle(1);
      check("stall cnt5 out_valid", int'(o_valid[3]), 0);
    end
    for (int k = 0; k < 3; k++) drive(7'b0001000, rnd13(), rnd13());
    for (int j = 0; j < 3; j++) begin
      idle(1);
      check("stall cnt8 out_valid", int'(o_valid[3]), 0);
    end
    for (int k = 0; k < 24; k++) drive(7'b0001000, rnd13(), rnd13());
    idle(1);

    // asynchronous reset with DEPTH=16 at cnt=20
    for (int k = 0; k < 4; k++) begin
      drive(7'b0000001, rnd13(), rnd13());
      check("pre-reset out_valid", int'(o_valid[0]), 1);
    end
    #1;
    rst_n = 1'b0;
    #1;
    check_all_zero("async reset");
    idle(1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      drive(7'b0000001, rnd13(), rnd13());
      check("post-reset out_valid", int'(o_valid[0]), (k == 17) ? 1 : 0);
    end
    idle(1);

    // random streams into every instance, with gaps, then a zero flush
    for (int k = 0; k < 1500; k++) begin
      @(negedge clk);
      in_valid = ($urandom_range(0, 9) < 8);
      sel      = '1;
      in_re    = 13'(rnd13());
      in_im    = 13'(rnd13());
    end
    for (int k = 0; k < 16; k++) drive('1, 0, 0);
    idle(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    n_tests++;
    n_fail++;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/ifft_r2sdf_stage.md
# ifft_r2sdf_stage

Radix-2 single-path delay-feedback (R2SDF) butterfly stage of the 32-point IFFT datapath. It takes a stream of complex S3.9 samples, forms the decimation-in-frequency sum/difference pairs, and emits them in order. Alongside each output sample it issues the twiddle-ROM address, so the ROM's S1.10 coefficient and this block's S3.9 output arrive together at the 13-bit twiddle multipliers. The block is instantiated once per stage with a different `DEPTH`.

## Interface
- `DEPTH`, 16: delay-line length. 32-pt stages use 16, 8, 4, 2, 1. Must be a power of two, at most 16.
- `SCALE`, 0: output scaling.
  - 1: sum and diff arithmetic-shifted right by 1 (1/2 per stage).
  - 0: sum and diff saturated instead.
- `clk`  in  1  rising-edge clock, single clock domain.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  input sample strobe. All state advances only on cycles where it is 1.
- `in_re`, `in_im`  in  13 each  signed S3.9 input sample.
- `out_valid`  out  1  output sample strobe (registered).
- `out_re`, `out_im`  out  13 each  signed S3.9 output (registered). Drives multiplier port A.
- `tw_addr`  out  4  twiddle ROM index (registered). Aligned with `out_re`/`out_im`.
- `tw_en`  out  1  1 = sample needs the twiddle at `tw_addr`; 0 = pass-through (W^0).

## Operation
- Counter `cnt`, range 0..2·DEPTH−1:
  - increments by 1 on each `in_valid` cycle and wraps to 0.
  - phase = `cnt >= DEPTH`; slot = `cnt mod DEPTH`.
- Delay line: DEPTH complex entries, read and written at the current slot (circular buffer or shift register). `d` = the entry leaving the line this cycle.
- Phase 0 (fill):
  - the input is written into the line;
  - the output is `d`, which holds the previous block's difference;
  - `tw_en`=1; `tw_addr` = slot·(16/DEPTH).
- Phase 1 (butterfly):
  - sum = `d` + input, computed 14 bits wide, goes to the output;
  - diff = `d` − input, computed 14 bits wide, is written into the line;
  - `tw_en`=0; `tw_addr`=0.
- Width rules:
  - SCALE=1: result = 14-bit value >>> 1. This floors, e.g. −3 → −2. No saturation is needed.
  - SCALE=0: result is clamped to [−4096, 4095], with 14-bit intermediate.
  - Real and imaginary parts are processed independently.
- `primed` flag:
  - cleared at reset;
  - set on the first phase-1 sample ever processed.
- `out_valid`:
  - always 1 for phase-1 inputs;
  - 1 for phase-0 inputs only when `primed`=1.
  - The first DEPTH samples after reset therefore produce no output.
- Tail flush: a block's differences leave the stage only while the next block's first half enters. Upstream pushes DEPTH zero samples after the last frame.

## Timing
- Latency: registered outputs update on the same edge that consumes an `in_valid` sample, so they are visible the cycle after the input.
- `in_valid`=0:
  - `cnt`, the delay line, `primed`, `out_re`, `out_im`, `tw_addr` and `tw_en` hold;
  - `out_valid` goes 0 on the next edge.
- No back-pressure: every valid input is accepted.
- Twiddle ROM is combinational. `tw_addr` is valid in the same cycle as the matching `out_*`.
- Reset (asynchronous, at any time including mid-frame):
  - `cnt`=0, `primed`=0;
  - `out_valid`=0, `out_re`=0, `out_im`=0, `tw_addr`=0, `tw_en`=0.
  - Delay-line contents are don't-care; they are masked by `primed`.
- Wrap: the edge that consumes the sample at `cnt`=2·DEPTH−1 sets `cnt` to 0 (phase 0). There is no gap between blocks.
- DEPTH=1: phases alternate every sample; `tw_addr` is always 0.

## Test plan
- Reset:
  - stimulus: assert `rst_n`=0 mid-stream, with `cnt`=20.
  - response: all outputs go 0 immediately, without a clock edge. After release, 16 inputs give `out_valid`=0 and the 17th gives `out_valid`=1.
- DC frame (DEPTH=16, SCALE=0):
  - stimulus: 32 samples of re=512 (1.0), im=0, then 16 zeros.
  - response: outputs 1..16 are re=1024, `tw_en`=0, `tw_addr`=0. Outputs 17..32 are re=0, `tw_en`=1, `tw_addr`=0..15 ascending.
- Saturation (SCALE=0, DEPTH=1):
  - stimulus: first sample re=3072, second re=3072.
  - response: out re=4095; the stored diff gives re=0 on the next output.
  - stimulus: pair 3072 then −3072.
  - response: sum re=0; diff clamps to 4095.
  - stimulus: pair −3072 then 3072.
  - response: diff re=−4096.
- Scaling (SCALE=1, DEPTH=1):
  - stimulus: pair 3072, 3072.
  - response: out re=3072.
  - stimulus: pair −3, 0.
  - response: out re=−2, then the diff output re=−2.
- Stalls (DEPTH=8):
  - stimulus: drop `in_valid` for 3 cycles at `cnt`=5 and at `cnt`=8.
  - response: `out_valid`=0 during the stalls, data and `tw_addr` held, and results bit-identical to the unstalled run.
- Stage addressing (DEPTH=4):
  - stimulus: any phase-0 slots 0..3.
  - response: `tw_addr`=0, 4, 8, 12.
